alu_cmd_issuer: RTL and testbench
=================================

Name: alu_cmd_issuer

Overview:
Sequential initiator for the 8-bit combinational ALU. It accepts single operations over a valid/ready command port and drives the ALU operand/opcode inputs from registers. It samples the ALU outputs after one settle cycle and returns them on a valid/ready response port. A hardware sweep mode issues every opcode against one operand pair, giving a built-in self-exercise of the ALU.

Parameters:
DW, 8, operand/result width (mulresult is 2*DW)
OPW, 3, opcode width; sweep covers 0..2^OPW-1
CW, 16, width of response counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  issuer can accept command
cmd_a  in  DW  operand A (also sweep operand A)
cmd_b  in  DW  operand B (also sweep operand B)
cmd_op  in  OPW  opcode
sweep_start  in  1  single-cycle request to run opcode sweep
sweep_busy  out  1  sweep in progress
alu_a  out  DW  to ALU A
alu_b  out  DW  to ALU B
alu_opcode  out  OPW  to ALU opcode
alu_result  in  DW  from ALU result
alu_carry  in  1  from ALU carry
alu_zero  in  1  from ALU zero
alu_mulresult  in  2*DW  from ALU mulresult
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_op  out  OPW  opcode that produced the response
rsp_result  out  DW  captured result
rsp_mulresult  out  2*DW  captured mulresult
rsp_carry  out  1  captured carry
rsp_zero  out  1  captured zero
rsp_count  out  CW  number of responses handed off, wraps

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs are 0: alu_*, rsp_*, rsp_count, sweep_busy, cmd_ready. cmd_ready may rise in the first cycle after release. Any in-flight op or sweep is discarded with no response.
- FSM states are IDLE, SETTLE, RESP.
- IDLE: cmd_ready=1.
  - At an edge with sweep_start=1, load alu_a/alu_b from cmd_a/cmd_b and alu_opcode=0, set sweep_busy=1, go to SETTLE. cmd_valid is ignored that cycle; sweep has priority, and cmd_ready is combinationally low when sweep_start=1.
  - Else, at an edge with cmd_valid=1, load alu_a/b/opcode from cmd_a/b/op and go to SETTLE.
- SETTLE: cmd_ready=0. alu_* are held. At the next edge, capture alu_result/carry/zero/mulresult and alu_opcode into rsp_*, set rsp_valid=1, go to RESP.
- RESP: rsp_valid=1; rsp_* and alu_* are held stable.
  - At an edge with rsp_ready=1: rsp_valid falls (unless a new capture occurs that edge) and rsp_count increments, wrapping 2^CW-1 -> 0.
  - Not sweeping: go to IDLE.
  - Sweeping with alu_opcode < 2^OPW-1: alu_opcode+1, go to SETTLE.
  - Sweeping with the last opcode: sweep_busy=0, go to IDLE.
- Latency: cmd accept edge E0 -> alu_* valid after E0 -> rsp_valid high after E1. Minimum issue interval is 3 cycles. A full sweep is 2^OPW responses with operands fixed.
- sweep_start outside IDLE is ignored; it is not queued.
- rsp_ready while rsp_valid=0 has no effect.
- Backpressure: RESP lasts indefinitely; the response must not change while rsp_valid=1 and rsp_ready=0.
- No arithmetic on ALU data; values are passed through bit-exact. Only alu_opcode and rsp_count are incremented, both modulo their widths.

Decomposition:
- Shared package alu_pkg: DW/OPW defaults, state encoding (IDLE=2'd0, SETTLE=2'd1, RESP=2'd2), OP_LAST = 2^OPW-1.
- Single module; no sub-module. The response register bank is inline.
- Bench instantiates the existing alu connected to the alu_* ports.

Test Plan:
- Single cmd A=44,B=11,op=0, rsp_ready=1 -> alu_a/b/opcode=44/11/0 one cycle after accept; rsp_valid two cycles after accept; rsp_* equal ALU outputs for (44,11,0); rsp_count=1.
- sweep_start with cmd_a=44,cmd_b=11 -> 8 responses with rsp_op 0..7 in order; each matches the ALU for (44,11,op); sweep_busy drops after the 8th handshake; rsp_count=8.
- A=200,B=100,op=0 with rsp_ready=0 for 5 cycles -> rsp_* and alu_* stable for all 5 cycles; cmd_ready=0 throughout; one handshake when rsp_ready=1; rsp_carry matches the ALU carry for 200+100 under op 0.
- sweep_start and cmd_valid in the same IDLE cycle -> sweep runs (rsp_op=0 first, operands from cmd_a/b); command not consumed; command accepted after the sweep ends.
- rst_n asserted during SETTLE of a sweep at op=3 -> all outputs 0 immediately; no response; after release a new cmd A=1,B=2,op=5 completes normally; rsp_count=1.
- Preload 2^CW-1 responses via a reduced CW=2 build (4 handshakes) -> rsp_count sequence 1,2,3,0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, FSM encoding and opcode limit for the ALU command issuer
package alu_pkg;
  localparam int DW_DEF  = 8;
  localparam int OPW_DEF = 3;
  localparam int CW_DEF  = 16;
  localparam logic [OPW_DEF-1:0] OP_LAST = OPW_DEF'((1 << OPW_DEF) - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;
endpackage

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - registers ALU operands, samples results after one settle cycle, optional opcode sweep
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int OPW = OPW_DEF,
  parameter int CW  = CW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DW-1:0]     cmd_a,
  input  logic [DW-1:0]     cmd_b,
  input  logic [OPW-1:0]    cmd_op,
  input  logic              sweep_start,
  output logic              sweep_busy,
  output logic [DW-1:0]     alu_a,
  output logic [DW-1:0]     alu_b,
  output logic [OPW-1:0]    alu_opcode,
  input  logic [DW-1:0]     alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero,
  input  logic [2*DW-1:0]   alu_mulresult,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [OPW-1:0]    rsp_op,
  output logic [DW-1:0]     rsp_result,
  output logic [2*DW-1:0]   rsp_mulresult,
  output logic              rsp_carry,
  output logic              rsp_zero,
  output logic [CW-1:0]     rsp_count
);

  localparam logic [OPW-1:0] OP_MAX = '1;

  state_t state, state_nxt;
  // Keeps cmd_ready low while reset is asserted and for the edge that releases it.
  logic   live;
  logic   load_cmd, load_sweep, capture, handoff, step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      live  <= 1'b0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    cmd_ready  = 1'b0;
    load_cmd   = 1'b0;
    load_sweep = 1'b0;
    capture    = 1'b0;
    handoff    = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = live && !sweep_start;
        if (live && sweep_start) begin
          load_sweep = 1'b1;
          state_nxt  = SETTLE;
        end else if (live && cmd_valid) begin
          load_cmd  = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        capture   = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          handoff = 1'b1;
          if (sweep_busy && alu_opcode != OP_MAX) begin
            step      = 1'b1;
            state_nxt = SETTLE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a         <= '0;
      alu_b         <= '0;
      alu_opcode    <= '0;
      sweep_busy    <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_op        <= '0;
      rsp_result    <= '0;
      rsp_mulresult <= '0;
      rsp_carry     <= 1'b0;
      rsp_zero      <= 1'b0;
      rsp_count     <= '0;
    end else begin
      if (load_sweep) begin
        alu_a      <= cmd_a;
        alu_b      <= cmd_b;
        alu_opcode <= '0;
        sweep_busy <= 1'b1;
      end else if (load_cmd) begin
        alu_a      <= cmd_a;
        alu_b      <= cmd_b;
        alu_opcode <= cmd_op;
      end
      if (capture) begin
        rsp_valid     <= 1'b1;
        rsp_op        <= alu_opcode;
        rsp_result    <= alu_result;
        rsp_mulresult <= alu_mulresult;
        rsp_carry     <= alu_carry;
        rsp_zero      <= alu_zero;
      end
      if (handoff) begin
        rsp_valid <= 1'b0;
        rsp_count <= rsp_count + 1'b1;
        if (step) begin
          alu_opcode <= alu_opcode + 1'b1;
        end else if (sweep_busy) begin
          sweep_busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - directed bench for alu_cmd_issuer with a behavioural ALU on the alu_* ports
module tb_alu_cmd_issuer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic [7:0] cmd_a = '0, cmd_b = '0;
  logic [2:0] cmd_op = '0;
  logic sweep_start = 1'b0;
  logic rsp_ready = 1'b0;

  logic cmd_ready, sweep_busy, rsp_valid, rsp_carry, rsp_zero;
  logic [7:0] alu_a, alu_b, rsp_result, alu_result;
  logic [2:0] alu_opcode, rsp_op;
  logic alu_carry, alu_zero;
  logic [15:0] alu_mulresult, rsp_mulresult, rsp_count;

  logic cmd_ready2, sweep_busy2, rsp_valid2, rsp_carry2, rsp_zero2;
  logic [7:0] alu_a2, alu_b2, rsp_result2, alu_result2;
  logic [2:0] alu_opcode2, rsp_op2;
  logic alu_carry2, alu_zero2;
  logic [15:0] alu_mulresult2, rsp_mulresult2;
  logic [1:0] rsp_count2;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  // Reference ALU: {mulresult, zero, carry, result}
  function automatic logic [25:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic [8:0] r;
    case (op)
      3'd0: r = {1'b0, a} + {1'b0, b};
      3'd1: r = {1'b0, a} - {1'b0, b};
      3'd2: r = {1'b0, a & b};
      3'd3: r = {1'b0, a | b};
      3'd4: r = {1'b0, a ^ b};
      3'd5: r = {1'b0, ~a};
      3'd6: r = {a[7], a[6:0], 1'b0};
      default: r = {a[0], 1'b0, a[7:1]};
    endcase
    return {16'(a * b), (r[7:0] == 8'd0), r[8], r[7:0]};
  endfunction

  assign {alu_mulresult, alu_zero, alu_carry, alu_result}     = alu_f(alu_a, alu_b, alu_opcode);
  assign {alu_mulresult2, alu_zero2, alu_carry2, alu_result2} = alu_f(alu_a2, alu_b2, alu_opcode2);

  alu_cmd_issuer u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_mulresult(alu_mulresult),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
    .rsp_result(rsp_result), .rsp_mulresult(rsp_mulresult),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_count(rsp_count)
  );

  alu_cmd_issuer #(.CW(2)) u_dut_cw2 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy2),
    .alu_a(alu_a2), .alu_b(alu_b2), .alu_opcode(alu_opcode2),
    .alu_result(alu_result2), .alu_carry(alu_carry2), .alu_zero(alu_zero2),
    .alu_mulresult(alu_mulresult2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_op(rsp_op2),
    .rsp_result(rsp_result2), .rsp_mulresult(rsp_mulresult2),
    .rsp_carry(rsp_carry2), .rsp_zero(rsp_zero2), .rsp_count(rsp_count2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic any_out();
    return |{cmd_ready, sweep_busy, alu_a, alu_b, alu_opcode, rsp_valid, rsp_op,
             rsp_result, rsp_mulresult, rsp_carry, rsp_zero, rsp_count};
  endfunction

  // Hand-computed ALU results for A=44, B=11, opcodes 0..7; mulresult 484, carry and zero 0 throughout.
  logic [7:0] sweep_res [8] = '{8'd55, 8'd33, 8'd8, 8'd47, 8'd39, 8'd211, 8'd88, 8'd22};

  task automatic run_sweep(input int count_base);
    for (int op = 0; op < 8; op++) begin
      tick;
      check($sformatf("sweep_valid_%0d", op), rsp_valid, 1);
      check($sformatf("sweep_op_%0d", op), rsp_op, op);
      check($sformatf("sweep_res_%0d", op), rsp_result, sweep_res[op]);
      check($sformatf("sweep_flags_%0d", op), {rsp_carry, rsp_zero}, 0);
      check($sformatf("sweep_mul_%0d", op), rsp_mulresult, 484);
      check($sformatf("sweep_busy_%0d", op), sweep_busy, 1);
      tick;
      check($sformatf("sweep_cnt_%0d", op), rsp_count, count_base + op + 1);
    end
    check("sweep_busy_end", sweep_busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick;
    tick;
    check("reset_outputs", any_out(), 0);
    rst_n = 1'b1;
    tick;
    check("ready_after_release", cmd_ready, 1);

    // Single command 44 + 11
    cmd_valid = 1'b1; cmd_a = 8'd44; cmd_b = 8'd11; cmd_op = 3'd0; rsp_ready = 1'b1;
    tick;
    cmd_valid = 1'b0;
    check("single_alu", {alu_a, alu_b, 5'd0, alu_opcode}, {8'd44, 8'd11, 8'd0});
    check("single_not_ready", cmd_ready, 0);
    check("single_no_rsp_yet", rsp_valid, 0);
    tick;
    check("single_rsp", {rsp_valid, rsp_op, rsp_result, rsp_carry, rsp_zero}, {1'b1, 3'd0, 8'd55, 2'b00});
    check("single_mul", rsp_mulresult, 484);
    tick;
    check("single_handoff", {rsp_valid, rsp_count}, {1'b0, 16'd1});

    // Plain sweep
    sweep_start = 1'b1;
    #1 check("sweep_ready_gated", cmd_ready, 0);
    tick;
    sweep_start = 1'b0;
    check("sweep_load", {sweep_busy, alu_opcode}, {1'b1, 3'd0});
    run_sweep(1);
    check("sweep_count", rsp_count, 9);

    // Backpressure with carry-out
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_a = 8'd200; cmd_b = 8'd100; cmd_op = 3'd0;
    tick;
    cmd_valid = 1'b0;
    tick;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_rsp_%0d", i), {rsp_valid, rsp_result, rsp_carry, rsp_zero}, {1'b1, 8'd44, 2'b10});
      check($sformatf("bp_mul_%0d", i), rsp_mulresult, 20000);
      check($sformatf("bp_alu_%0d", i), {alu_a, alu_b}, {8'd200, 8'd100});
      check($sformatf("bp_ready_%0d", i), cmd_ready, 0);
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    check("bp_handoff", {rsp_valid, rsp_count}, {1'b0, 16'd10});

    // Sweep and command together: sweep wins, command waits
    cmd_valid = 1'b1; cmd_a = 8'd44; cmd_b = 8'd11; cmd_op = 3'd2; sweep_start = 1'b1;
    tick;
    sweep_start = 1'b0;
    check("combo_sweep_first", {sweep_busy, alu_opcode}, {1'b1, 3'd0});
    run_sweep(10);
    check("combo_ready_after", cmd_ready, 1);
    tick;
    cmd_valid = 1'b0;
    check("combo_cmd_taken", alu_opcode, 2);
    tick;
    check("combo_rsp", {rsp_op, rsp_result}, {3'd2, 8'd8});
    tick;
    check("combo_count", rsp_count, 19);

    // Reset in SETTLE at op 3 of a sweep
    sweep_start = 1'b1;
    tick;
    sweep_start = 1'b0;
    for (int i = 0; i < 6; i++) tick;
    check("pre_reset_state", {sweep_busy, alu_opcode, rsp_valid}, {1'b1, 3'd3, 1'b0});
    rst_n = 1'b0;
    #1 check("async_reset_outputs", any_out(), 0);
    tick;
    rst_n = 1'b1;
    tick;
    check("post_reset_idle", {cmd_ready, rsp_valid, sweep_busy}, 3'b100);
    cmd_valid = 1'b1; cmd_a = 8'd1; cmd_b = 8'd2; cmd_op = 3'd5;
    tick;
    cmd_valid = 1'b0;
    tick;
    check("post_reset_rsp", {rsp_valid, rsp_op, rsp_result, rsp_carry, rsp_zero}, {1'b1, 3'd5, 8'd254, 2'b00});
    check("post_reset_mul", rsp_mulresult, 2);
    tick;
    check("post_reset_count", rsp_count, 1);
    check("cw2_count_1", rsp_count2, 1);

    // Narrow counter wraps 1,2,3,0
    for (int k = 2; k <= 4; k++) begin
      cmd_valid = 1'b1; cmd_a = 8'(k); cmd_b = 8'd3; cmd_op = 3'd3;
      tick;
      cmd_valid = 1'b0;
      tick;
      tick;
      check($sformatf("cw2_count_%0d", k), rsp_count2, k % 4);
      check($sformatf("cw16_count_%0d", k), rsp_count, k);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
